alu_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_core.sv | 24 ++
 rtl/alu_pipe.sv | 66 ++++++
 tb/tb_alu_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map and width-generic ALU evaluation shared by the pipeline
package alu_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_AND, OP_OR, OP_XOR, OP_EQ} alu_op_e;
  typedef struct packed {
    logic [63:0] res;
    logic        carry;
  } alu_res_t;
  // Operands are zero-extended to 64 bits; w is the live width (<= 64), shw the shift-amount width
  function automatic alu_res_t alu_eval(input logic [63:0] a, input logic [63:0] b, input alu_op_e op,
                                        input logic [6:0] w, input logic [6:0] shw);
    alu_res_t   r;
    logic [63:0] m;
    logic [63:0] am;
    logic [63:0] bm;
    logic [63:0] sh;
    logic [64:0] sum;
    m   = (w >= 7'd64) ? '1 : (64'd1 << w) - 64'd1;
    am  = a & m;
    bm  = b & m;
    sh  = b & ((64'd1 << shw) - 64'd1);
    sum = {1'b0, am} + {1'b0, bm};
    r.carry = 1'b0;
    unique case (op)
      OP_ADD: begin
        r.res   = sum[63:0] & m;
        r.carry = sum[w];
      end
      OP_SUB: begin
        r.res   = (am - bm) & m;
        r.carry = am < bm;
      end
      OP_SLL:  r.res = (am << sh) & m;
      OP_SRL:  r.res = am >> sh;
      OP_AND:  r.res = am & bm;
      OP_OR:   r.res = am | bm;
      OP_XOR:  r.res = am ^ bm;
      OP_EQ:   r.res = {63'd0, am == bm};
      default: r.res = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU; ALU_SAT_EN makes ADD/SUB saturate on carry/borrow
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] res,
  output logic             carry
);
  alu_res_t r;
  logic     unused_hi;
  always_comb r = alu_eval(64'(a), 64'(b), op, 7'(WIDTH), 7'(SHW));
  assign unused_hi = ^r.res;
`ifdef ALU_SAT_EN
  assign res = (r.carry && op == OP_ADD) ? '1 : (r.carry && op == OP_SUB) ? '0 : r.res[WIDTH-1:0];
`else
  assign res = r.res[WIDTH-1:0];
`endif
  assign carry = r.carry;
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage valid/ready ALU pipeline (S1 operand regs, S2 result regs); ALU_SAT_EN selects saturating ADD/SUB
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] alu_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);
  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;
  logic [WIDTH-1:0] res;
  logic             carry;
  assign s2_adv      = !s2_valid || out_ready_i;
  assign s1_adv      = s1_valid && s2_adv;
  assign in_ready_o  = !s1_valid || s2_adv;
  assign out_valid_o = s2_valid;
  alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .a    (s1_a),
    .b    (s1_b),
    .op   (s1_op),
    .res  (res),
    .carry(carry)
  );
  // Operand registers need no reset: s1_valid gates their use
  always_ff @(posedge clk) begin
    if (in_valid_i && in_ready_o) begin
      s1_a  <= a_i;
      s1_b  <= b_i;
      s1_op <= op_i;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      alu_o    <= '0;
      carry_o  <= 1'b0;
      zero_o   <= 1'b0;
    end else begin
      if (in_ready_o) s1_valid <= in_valid_i;
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv) begin
        alu_o   <= res;
        carry_o <= carry;
        zero_o  <= res == '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH=8 (directed + random) and WIDTH=16 (random)
module tb_alu_pipe;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0]  a8, b8, alu8;
  logic [15:0] a16, b16, alu16;
  alu_op_e     op8, op16;
  logic        iv8, ir8, ov8, or8, c8, z8;
  logic        iv16, ir16, ov16, or16, c16, z16;
  logic [65:0] q8[$];
  logic [65:0] q16[$];
  int n_tests = 0;
  int n_fail = 0;
  int acc8 = 0;
  int acc16 = 0;
  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(rst_n), .a_i(a8), .b_i(b8), .op_i(op8), .in_valid_i(iv8), .in_ready_o(ir8),
    .alu_o(alu8), .carry_o(c8), .zero_o(z8), .out_valid_o(ov8), .out_ready_i(or8)
  );
  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(rst_n), .a_i(a16), .b_i(b16), .op_i(op16), .in_valid_i(iv16), .in_ready_o(ir16),
    .alu_o(alu16), .carry_o(c16), .zero_o(z16), .out_valid_o(ov16), .out_ready_i(or16)
  );
  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Reference model: returns {zero, carry, result zero-extended to 64 bits}
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input alu_op_e op, input int w);
    logic [63:0] m, r;
    logic [64:0] s;
    logic        c;
    int          sh;
    m  = (64'd1 << w) - 64'd1;
    sh = int'(b % 64'(w));
    s  = {1'b0, a} + {1'b0, b};
    c  = 1'b0;
    case (op)
      OP_ADD: begin r = s[63:0] & m; c = s[w]; end
      OP_SUB: begin r = (a - b) & m; c = a < b; end
      OP_SLL: r = (a << sh) & m;
      OP_SRL: r = a >> sh;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: r = {63'd0, a == b};
    endcase
`ifdef ALU_SAT_EN
    if (c && op == OP_ADD) r = m;
    if (c && op == OP_SUB) r = '0;
`endif
    return {r == 64'd0, c, r};
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      q16.delete();
    end else begin
      if (ov8 && or8) begin
        if (q8.size() == 0) chk("stale8", 66'(ov8), 66'(0));
        else chk("res8", {z8, c8, 64'(alu8)}, q8.pop_front());
      end
      if (ov16 && or16) begin
        if (q16.size() == 0) chk("stale16", 66'(ov16), 66'(0));
        else chk("res16", {z16, c16, 64'(alu16)}, q16.pop_front());
      end
      if (iv8 && ir8) begin
        q8.push_back(model(64'(a8), 64'(b8), op8, 8));
        acc8++;
      end
      if (iv16 && ir16) begin
        q16.push_back(model(64'(a16), 64'(b16), op16, 16));
        acc16++;
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input alu_op_e op);
    int k = 0;
    a8 = a; b8 = b; op8 = op; iv8 = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!ir8 && k < 50);
    if (!ir8) chk("accept_timeout", 66'(ir8), 66'(1));
    @(posedge clk);
    #1;
    iv8 = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int base8, base16;
    iv8 = 0; or8 = 1; a8 = 0; b8 = 0; op8 = OP_ADD;
    iv16 = 0; or16 = 1; a16 = 0; b16 = 0; op16 = OP_ADD;
    idle(2);
    chk("rst_valid8", 66'(ov8), 66'(0));
    chk("rst_out8", {z8, c8, 64'(alu8)}, 66'(0));
    chk("rst_ready8", 66'(ir8), 66'(1));
    chk("rst_valid16", 66'(ov16), 66'(0));
    rst_n = 1;
    idle(1);
    send8(8'h0A, 8'h14, OP_ADD);
    chk("lat_cycle1", 66'(ov8), 66'(0));
    idle(1);
    chk("lat_cycle2", 66'(ov8), 66'(1));
    chk("add_val", {z8, c8, 64'(alu8)}, {2'b00, 64'h1E});
    send8(8'h0A, 8'h14, OP_SUB);
    send8(8'hFF, 8'h02, OP_ADD);
    send8(8'h81, 8'h09, OP_SLL);
    send8(8'h81, 8'h09, OP_SRL);
    send8(8'h0A, 8'h14, OP_AND);
    send8(8'h0A, 8'h14, OP_OR);
    send8(8'h0A, 8'h14, OP_XOR);
    send8(8'h55, 8'h55, OP_EQ);
    send8(8'h55, 8'h54, OP_EQ);
    send8(8'h80, 8'h80, OP_ADD);
    idle(5);
    or8 = 0;
    send8(8'h01, 8'h01, OP_ADD);
    send8(8'h02, 8'h02, OP_ADD);
    a8 = 8'h03; b8 = 8'h03; op8 = OP_ADD; iv8 = 1;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready", 66'(ir8), 66'(0));
      chk("hold_valid", 66'(ov8), 66'(1));
      chk("hold_val", 66'(alu8), 66'(2));
    end
    @(posedge clk);
    #1;
    or8 = 1;
    @(negedge clk);
    chk("release_ready", 66'(ir8), 66'(1));
    @(posedge clk);
    #1;
    iv8 = 0;
    idle(5);
    chk("bp_drained", 66'(q8.size()), 66'(0));
    base8 = acc8;
    base16 = acc16;
    for (int cyc = 0; cyc < 3000 && (acc8 - base8 < 100 || acc16 - base16 < 100); cyc++) begin
      iv8 = (acc8 - base8 < 100) && ($urandom_range(3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); op8 = alu_op_e'($urandom_range(7));
      or8 = $urandom_range(3) != 0;
      iv16 = (acc16 - base16 < 100) && ($urandom_range(3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); op16 = alu_op_e'($urandom_range(7));
      or16 = $urandom_range(3) != 0;
      idle(1);
    end
    iv8 = 0; iv16 = 0; or8 = 1; or16 = 1;
    idle(10);
    chk("rand_count8", 66'(acc8 - base8 >= 100), 66'(1));
    chk("rand_count16", 66'(acc16 - base16 >= 100), 66'(1));
    chk("rand_drained8", 66'(q8.size()), 66'(0));
    chk("rand_drained16", 66'(q16.size()), 66'(0));
    or8 = 0;
    send8(8'h05, 8'h05, OP_ADD);
    send8(8'h06, 8'h06, OP_OR);
    idle(1);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    chk("midrst_valid", 66'(ov8), 66'(0));
    chk("midrst_out", {z8, c8, 64'(alu8)}, 66'(0));
    or8 = 1;
    idle(6);
    chk("midrst_quiet", 66'(ov8), 66'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
